// File: rtl/median_pkg.sv
// median_pkg: types and defaults shared by the window generator and the
// median pipeline it feeds.
//   DEF_PIX_W / DEF_IMG_W : default pixel width and line length
//   pix_t                 : one pixel at the default width
//   row_t                 : how many complete prior lines are buffered
package median_pkg;

    localparam int DEF_PIX_W = 8;
    localparam int DEF_IMG_W = 8;

    typedef logic [DEF_PIX_W-1:0] pix_t;

    // ROW_FULL means two complete earlier lines sit in the line buffers.
    typedef enum logic [1:0] {
        ROW_0    = 2'd0,
        ROW_1    = 2'd1,
        ROW_FULL = 2'd2
    } row_t;

    // Row count advances once per completed line and saturates at ROW_FULL.
    function automatic row_t row_advance(input row_t r);
        row_t n;
        n = ROW_FULL;
        if (r == ROW_0) begin
            n = ROW_1;
        end
        return n;
    endfunction

endpackage

// File: rtl/median_window_gen_if.sv
// median_window_gen_if: pixel stream in, 3x3 window out.
//   pix_valid/pix_in/sof : raster pixel stream (no backpressure)
//   win_valid            : one-cycle pulse, A..I/win_col carry a new window
//   A..C / D..F / G..I   : top / middle / bottom window rows, left to right
//   win_col              : column of the window centre (E)
// Handshake: a pixel is taken on every rising edge where pix_valid=1; the
// consumer is always ready, so win_valid needs no acknowledge.
interface median_window_gen_if
    import median_pkg::*;
#(
    parameter int PIX_W = DEF_PIX_W,
    parameter int COL_W = $clog2(DEF_IMG_W)
);
    logic             pix_valid;
    logic [PIX_W-1:0] pix_in;
    logic             sof;
    logic             win_valid;
    logic [PIX_W-1:0] A, B, C, D, E, F, G, H, I;
    logic [COL_W-1:0] win_col;

    modport master (
        output pix_valid, pix_in, sof,
        input  win_valid, A, B, C, D, E, F, G, H, I, win_col
    );

    modport slave (
        input  pix_valid, pix_in, sof,
        output win_valid, A, B, C, D, E, F, G, H, I, win_col
    );
endinterface

// File: rtl/median_window_gen_line_buffer.sv
// line_buffer: one image line of storage, indexed by column.
//   clk     : write clock
//   we_i    : write rdata's slot with wdata_i at the next rising edge
//   addr_i  : column address, shared by read and write
//   wdata_i : pixel to store
//   rdata_o : current contents at addr_i (old value during a write cycle)
// Storage is not reset; the window generator never emits unwritten slots.
module line_buffer
    import median_pkg::*;
#(
    parameter int PIX_W = DEF_PIX_W,
    parameter int IMG_W = DEF_IMG_W,
    parameter int COL_W = $clog2(IMG_W)
) (
    input  logic             clk,
    input  logic             we_i,
    input  logic [COL_W-1:0] addr_i,
    input  logic [PIX_W-1:0] wdata_i,
    output logic [PIX_W-1:0] rdata_o
);
    logic [PIX_W-1:0] mem_q [IMG_W];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    // Combinational read gives read-before-write within one accept cycle.
    assign rdata_o = mem_q[addr_i];
endmodule

// File: rtl/median_window_gen.sv
// median_window_gen: streaming 3x3 neighbourhood generator.
//   clk, rst_n : clock, asynchronous active-low reset
//   win_if     : slave side of median_window_gen_if (pixel stream in,
//                window A..I + win_col + win_valid out)
// Two line buffers hold lines r-1 and r-2; three 3-deep shift registers form
// the window. A window is flagged one cycle after accepting a pixel with two
// full prior lines present and col>=2, so all nine taps are from this frame.
module median_window_gen
    import median_pkg::*;
#(
    parameter int PIX_W = DEF_PIX_W,
    parameter int IMG_W = DEF_IMG_W,
    parameter int COL_W = $clog2(IMG_W)
) (
    input  logic                clk,
    input  logic                rst_n,
    median_window_gen_if.slave  win_if
);
    logic [COL_W-1:0] col_q, col_d;
    row_t             row_q, row_d;
    logic [PIX_W-1:0] top_q [3], top_d [3];
    logic [PIX_W-1:0] mid_q [3], mid_d [3];
    logic [PIX_W-1:0] bot_q [3], bot_d [3];
    logic             win_valid_q, win_valid_d;
    logic [COL_W-1:0] win_col_q, win_col_d;

    logic [COL_W-1:0] cur_col;
    row_t             cur_row;
    logic             last_col;
    logic [PIX_W-1:0] lb0_rd, lb1_rd;

    // sof forces this pixel to (0,0), abandoning whatever came before.
    assign cur_col  = win_if.sof ? '0 : col_q;
    assign cur_row  = win_if.sof ? ROW_0 : row_q;
    assign last_col = (cur_col == COL_W'(IMG_W - 1));

    line_buffer #(.PIX_W(PIX_W), .IMG_W(IMG_W), .COL_W(COL_W)) u_lb0 (
        .clk     (clk),
        .we_i    (win_if.pix_valid),
        .addr_i  (cur_col),
        .wdata_i (win_if.pix_in),
        .rdata_o (lb0_rd)
    );

    // lb1 takes the line that lb0 is about to overwrite.
    line_buffer #(.PIX_W(PIX_W), .IMG_W(IMG_W), .COL_W(COL_W)) u_lb1 (
        .clk     (clk),
        .we_i    (win_if.pix_valid),
        .addr_i  (cur_col),
        .wdata_i (lb0_rd),
        .rdata_o (lb1_rd)
    );

    always_comb begin
        col_d       = col_q;
        row_d       = row_q;
        top_d       = top_q;
        mid_d       = mid_q;
        bot_d       = bot_q;
        win_valid_d = 1'b0;
        win_col_d   = win_col_q;
        if (win_if.pix_valid) begin
            col_d    = last_col ? '0 : cur_col + COL_W'(1);
            row_d    = last_col ? row_advance(cur_row) : cur_row;
            top_d[0] = top_q[1];
            top_d[1] = top_q[2];
            top_d[2] = lb1_rd;
            mid_d[0] = mid_q[1];
            mid_d[1] = mid_q[2];
            mid_d[2] = lb0_rd;
            bot_d[0] = bot_q[1];
            bot_d[1] = bot_q[2];
            bot_d[2] = win_if.pix_in;
            if (cur_row == ROW_FULL && cur_col >= COL_W'(2)) begin
                win_valid_d = 1'b1;
                win_col_d   = cur_col - COL_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q       <= '0;
            row_q       <= ROW_0;
            top_q       <= '{default: '0};
            mid_q       <= '{default: '0};
            bot_q       <= '{default: '0};
            win_valid_q <= 1'b0;
            win_col_q   <= '0;
        end else begin
            col_q       <= col_d;
            row_q       <= row_d;
            top_q       <= top_d;
            mid_q       <= mid_d;
            bot_q       <= bot_d;
            win_valid_q <= win_valid_d;
            win_col_q   <= win_col_d;
        end
    end

    assign win_if.win_valid = win_valid_q;
    assign win_if.win_col   = win_col_q;
    assign win_if.A = top_q[0];
    assign win_if.B = top_q[1];
    assign win_if.C = top_q[2];
    assign win_if.D = mid_q[0];
    assign win_if.E = mid_q[1];
    assign win_if.F = mid_q[2];
    assign win_if.G = bot_q[0];
    assign win_if.H = bot_q[1];
    assign win_if.I = bot_q[2];
endmodule

// File: doc/median_window_gen.md
Name: median_window_gen

Overview:
Streaming 3x3 window generator that feeds the median filter pipeline.
- Accepts a raster-order pixel stream, one pixel per cycle when valid.
- Buffers the two previous lines.
- Presents each complete 3x3 neighbourhood on nine outputs named A..I, matching the pipeline's operand order, plus a window-valid strobe.
- Sits directly upstream of the median pipeline in the image path.

Parameters:
PIX_W, 8, pixel width in bits
IMG_W, 8, pixels per image line (legal range 3..1024)
COL_W, $clog2(IMG_W), column counter / line-buffer address width

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
pix_valid  input  1  pix_in is valid this cycle; pixel accepted
pix_in  input  PIX_W  raster-order pixel
sof  input  1  start of frame; qualifies pix_in as pixel (0,0); ignored unless pix_valid
win_valid  output  1  A..I hold a new complete window (one-cycle pulse per window)
A,B,C  output  PIX_W each  window top row (line r-2), left to right
D,E,F  output  PIX_W each  window middle row (line r-1), left to right
G,H,I  output  PIX_W each  window bottom row (line r), left to right
win_col  output  COL_W  column of window centre (E)

Behaviour:
- Reset (async, rst_n=0): win_valid=0, A..I=0, win_col=0, col=0, row=0. Line-buffer contents are don't-care and are never emitted; see the row gating below.
- No backpressure: downstream is always ready. Idle cycles (pix_valid=0) change no state, and win_valid=0 on those cycles.
- Counters on each accepted pixel:
  - col increments, wrapping IMG_W-1 -> 0.
  - On wrap, row increments, saturating at 2. Row only needs "two prior lines present".
- sof=1 with pix_valid: the pixel is treated as col=0, row=0 regardless of the current counters. Next col=1, row=0. A mid-line sof abandons the partial frame.
- Line buffers: two buffers, lb0 (line r-1) and lb1 (line r-2), each IMG_W deep, addressed by col. Read-before-write in the same accept cycle: lb1[col] <= lb0[col], lb0[col] <= pix_in.
- Window shift on accept (uses pre-write line-buffer values):
  - Top row: A<=B, B<=C, C<=lb1[col].
  - Middle row: D<=E, E<=F, F<=lb0[col].
  - Bottom row: G<=H, H<=I, I<=pix_in.
- Valid rule: win_valid <= 1 on the cycle after accepting pixel (row,col) with row==2 (saturated) and col>=2; otherwise 0. win_col <= col-1 at the same time.
- Latency: exactly 1 cycle from accepting the bottom-right pixel to win_valid.
- Borders: no padding. For an IMG_W x H frame, exactly (IMG_W-2)*(H-2) windows are produced.
- Stale columns: windows never span a line boundary. The col>=2 gate guarantees that three fresh columns have shifted in.
- sof during the first two lines of a new frame suppresses all windows, so stale line-buffer data is never emitted.
- Back-to-back frames with no gap are legal.
- sof together with an accepted pixel on the last column: the sof wins.

Decomposition:
- Package median_pkg: PIX_W default, IMG_W default, pix_t typedef (logic [PIX_W-1:0]). Shared with the median pipeline.
- Sub-module line_buffer: IMG_W x PIX_W, single address, read-before-write, write-enable = pix_valid, no reset on storage. Instantiated twice (lb0, lb1).
- The top level holds the counters, the 3x3 shift registers and the valid logic.

Test Plan:
1. Ramp frame, IMG_W=4, 4 lines, pixel = row*16+col, pix_valid continuous.
   - The first win_valid comes 1 cycle after pixel 0x22, with A..I = 00,01,02,10,11,12,20,21,22 and win_col=1.
   - Exactly 4 windows; the last is 11..33.
2. Same frame with pix_valid toggled randomly (50% idle).
   - Identical window sequence and values.
   - win_valid is never high twice for one window.
   - No valid pulse on idle cycles.
3. sof asserted at pixel (2,1) of frame 1, then a full frame 2 follows.
   - No window until frame-2 pixel (2,2).
   - No frame-1 data ever appears in A..I.
4. rst_n pulsed low mid-line-2, then a new frame is streamed.
   - All outputs are 0 immediately (async).
   - First window after new pixel (2,2) is correct.
5. Integration: windowed 4x4 frame feeding the median pipeline, with window 31,09,55,AB,33,01,7F,6D,2A.
   - Median output 0x33 on that window.
6. IMG_W=3 boundary: a 3x5 frame produces exactly 3 windows, all with win_col=1.
